tcam_match_engine: RTL

//  Next-generation data-plane TCAM: ternary lookup of a packet key against ENTRIES rules,

---
 rtl/tcam_match_engine.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tcam_match_engine.sv
// tcam_match_engine: ternary lookup of a KEY_W-bit key against ENTRIES rules.
// Each rule has a value, a mask (1 = don't care), a valid bit and an action word.
// The lookup runs in two pipeline stages:
//   - S1 registers the per-entry match vector.
//   - S2 does the lowest-index priority encode, multi-hit detect and action read.
// A sequential flush engine clears one valid bit per cycle.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   key, key_valid, key_ready  lookup request handshake (ready = !flush_busy)
//   wr_en, wr_sel, wr_addr,    control-plane table write
//     wr_data                    (sel 0 value, 1 mask, 2 action, 3 valid)
//   flush_req, flush_busy      start / status of whole-table invalidate
//   res_valid, res_hit,        one-cycle lookup result
//     res_index, res_action,
//     res_multi
//   hit_count                  saturating count of hit results

// Per-entry ternary compare.
module tcam_entry_cmp #(
  parameter int KEY_W = 128
) (
  input  logic [KEY_W-1:0] key,
  input  logic [KEY_W-1:0] value,
  input  logic [KEY_W-1:0] mask,
  input  logic             valid,
  output logic             hit
);
  assign hit = valid && ((key & ~mask) == (value & ~mask));
endmodule

module tcam_match_engine #(
  parameter int KEY_W   = 128,
  parameter int ENTRIES = 32,
  parameter int ACT_W   = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic             wr_en,
  input  logic [1:0]       wr_sel,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [KEY_W-1:0] wr_data,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             res_valid,
  output logic             res_hit,
  output logic [IDX_W-1:0] res_index,
  output logic [ACT_W-1:0] res_action,
  output logic             res_multi,
  output logic [31:0]      hit_count
);
  localparam int STAGES = 2;

  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state;
  logic [IDX_W-1:0] cnt;

  logic [ENTRIES-1:0][KEY_W-1:0] value_q, mask_q;
  logic [ENTRIES-1:0][ACT_W-1:0] act_q;
  logic [ENTRIES-1:0]            valid_q;

  logic [ENTRIES-1:0] match, s1_match;
  logic [STAGES:0]    vld_pipe;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_hit, enc_multi;

  assign key_ready   = !flush_busy;
  assign vld_pipe[0] = key_valid && key_ready;
  assign res_valid   = vld_pipe[STAGES];

  // Data arrays carry no reset; only the valid bits gate matching.
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) begin
      case (wr_sel)
        2'd0:    value_q[wr_addr] <= wr_data;
        2'd1:    mask_q[wr_addr]  <= wr_data;
        2'd2:    act_q[wr_addr]   <= wr_data[ACT_W-1:0];
        default: ;
      endcase
    end
  end

  // Valid bits and the flush FSM share one block. In IDLE a valid write
  // and a flush start can coincide: the write lands, then the flush clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      flush_busy <= 1'b0;
      valid_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en && wr_sel == 2'd3) valid_q[wr_addr] <= wr_data[0];
          if (flush_req) begin
            state      <= FLUSH;
            flush_busy <= 1'b1;
            cnt        <= '0;
          end
        end
        FLUSH: begin
          valid_q[cnt] <= 1'b0;
          cnt          <= cnt + IDX_W'(1);
          if (cnt == IDX_W'(ENTRIES - 1)) begin
            state      <= IDLE;
            flush_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_cmp
    tcam_entry_cmp #(.KEY_W(KEY_W)) u_cmp (
      .key   (key),
      .value (value_q[i]),
      .mask  (mask_q[i]),
      .valid (valid_q[i]),
      .hit   (match[i])
    );
  end

  // Lowest index wins: scan from the top so the last assignment is the lowest.
  always_comb begin
    enc_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (s1_match[i]) enc_idx = IDX_W'(i);
  end
  assign enc_hit   = |s1_match;
  // Clearing the lowest set bit leaves something iff two or more bits were set.
  assign enc_multi = |(s1_match & (s1_match - ENTRIES'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      s1_match           <= '0;
      res_hit            <= 1'b0;
      res_index          <= '0;
      res_action         <= '0;
      res_multi          <= 1'b0;
      hit_count          <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (vld_pipe[0]) s1_match <= match;
      if (vld_pipe[1]) begin
        res_hit    <= enc_hit;
        res_index  <= enc_idx;
        res_action <= enc_hit ? act_q[enc_idx] : '0;
        res_multi  <= enc_multi;
        if (enc_hit && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end
    end
  end
endmodule
